// File: rtl/multichannel_enable_delay.sv
// rtl/multichannel_enable_delay.sv - N-channel enable delay with independent rise/fall delays
// Each channel runs its own IDLE/RISE_WAIT/ACTIVE/FALL_WAIT machine; outputs are registered from next state.
module multichannel_enable_delay #(
    parameter int N_CHANNELS    = 4,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic [N_CHANNELS-1:0]               enable_i,
    input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] rise_delay_i,
    input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] fall_delay_i,
    output logic [N_CHANNELS-1:0]               delayed_enable_o,
    output logic [N_CHANNELS-1:0]               busy_o
);

    localparam int W = COUNTER_WIDTH;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RISE_WAIT = 2'd1,
        ACTIVE    = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    state_t         state_q [N_CHANNELS];
    state_t         state_d [N_CHANNELS];
    logic [W-1:0]   cnt_q   [N_CHANNELS];
    logic [W-1:0]   cnt_d   [N_CHANNELS];
    logic [N_CHANNELS-1:0] out_q, out_d;
    logic [N_CHANNELS-1:0] busy_q, busy_d;

    always_comb begin
        out_d  = '0;
        busy_d = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (enable_i[i]) begin
                        if (rise_delay_i[i*W +: W] == '0) begin
                            state_d[i] = ACTIVE;
                        end else begin
                            state_d[i] = RISE_WAIT;
                            cnt_d[i]   = rise_delay_i[i*W +: W];
                        end
                    end
                end
                RISE_WAIT: begin
                    // Dropping enable before the count expires swallows the pulse entirely.
                    if (!enable_i[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_ONE) begin
                        state_d[i] = ACTIVE;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                ACTIVE: begin
                    if (!enable_i[i]) begin
                        if (fall_delay_i[i*W +: W] == '0) begin
                            state_d[i] = IDLE;
                        end else begin
                            state_d[i] = FALL_WAIT;
                            cnt_d[i]   = fall_delay_i[i*W +: W];
                        end
                    end
                end
                FALL_WAIT: begin
                    if (enable_i[i]) begin
                        state_d[i] = ACTIVE;
                    end else if (cnt_q[i] == CNT_ONE) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
            out_d[i]  = (state_d[i] == ACTIVE) || (state_d[i] == FALL_WAIT);
            busy_d[i] = (state_d[i] == RISE_WAIT) || (state_d[i] == FALL_WAIT);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            out_q  <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            out_q  <= out_d;
            busy_q <= busy_d;
        end
    end

    assign delayed_enable_o = out_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_multichannel_enable_delay.sv
// tb/tb_multichannel_enable_delay.sv - scoreboard bench for multichannel_enable_delay (W=16 and W=4 instances)
module tb_multichannel_enable_delay;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int WS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic [N-1:0]     en  = '0;
    logic [N*W-1:0]   rd  = '0;
    logic [N*W-1:0]   fd  = '0;
    logic [N*WS-1:0]  rd4, fd4;
    logic [N-1:0]     de, bz, de4, bz4;

    logic [N*W-1:0]   rd_next = '0;
    logic [N*W-1:0]   fd_next = '0;

    for (genvar g = 0; g < N; g++) begin : g_narrow
        assign rd4[g*WS +: WS] = rd[g*W +: WS];
        assign fd4[g*WS +: WS] = fd[g*W +: WS];
    end

    multichannel_enable_delay #(.N_CHANNELS(N), .COUNTER_WIDTH(W)) dut (
        .clock_i(clk), .reset_i(rst), .enable_i(en),
        .rise_delay_i(rd), .fall_delay_i(fd),
        .delayed_enable_o(de), .busy_o(bz)
    );

    multichannel_enable_delay #(.N_CHANNELS(N), .COUNTER_WIDTH(WS)) dut4 (
        .clock_i(clk), .reset_i(rst), .enable_i(en),
        .rise_delay_i(rd4), .fall_delay_i(fd4),
        .delayed_enable_o(de4), .busy_o(bz4)
    );

    // Reference: an output change is scheduled as a deadline edge index rather than a countdown.
    bit  m_out  [2][N];
    bit  m_pend [2][N];
    int  m_due  [2][N];
    int  edge_k = 0;
    logic [4*N-1:0] exp_q [$];
    int  total = 0;
    int  bad   = 0;

    task automatic model_edge();
        logic [4*N-1:0] x;
        for (int inst = 0; inst < 2; inst++) begin
            for (int ch = 0; ch < N; ch++) begin
                int r, f, d;
                r = (inst == 0) ? int'(rd[ch*W +: W]) : int'(rd[ch*W +: WS]);
                f = (inst == 0) ? int'(fd[ch*W +: W]) : int'(fd[ch*W +: WS]);
                if (rst) begin
                    m_out[inst][ch]  = 1'b0;
                    m_pend[inst][ch] = 1'b0;
                end else if (m_pend[inst][ch]) begin
                    if (en[ch] == m_out[inst][ch]) begin
                        m_pend[inst][ch] = 1'b0;
                    end else if (edge_k == m_due[inst][ch]) begin
                        m_out[inst][ch]  = en[ch];
                        m_pend[inst][ch] = 1'b0;
                    end
                end else if (en[ch] != m_out[inst][ch]) begin
                    d = en[ch] ? r : f;
                    if (d == 0) begin
                        m_out[inst][ch] = en[ch];
                    end else begin
                        m_pend[inst][ch] = 1'b1;
                        m_due[inst][ch]  = edge_k + d;
                    end
                end
            end
        end
        for (int ch = 0; ch < N; ch++) begin
            x[ch]       = m_out[0][ch];
            x[N+ch]     = m_pend[0][ch];
            x[2*N+ch]   = m_out[1][ch];
            x[3*N+ch]   = m_pend[1][ch];
        end
        exp_q.push_back(x);
        edge_k++;
    endtask

    task automatic drive(input logic r, input logic [N-1:0] e, input int n);
        repeat (n) begin
            @(negedge clk);
            rst = r;
            en  = e;
            rd  = rd_next;
            fd  = fd_next;
            model_edge();
        end
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s edge=%0d actual=%b required=%b", name, edge_k, act, req);
        end
    endtask

    initial begin
        logic [4*N-1:0] x;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("out_w16",  de,  x[N-1:0]);
                check("busy_w16", bz,  x[2*N-1:N]);
                check("out_w4",   de4, x[3*N-1:2*N]);
                check("busy_w4",  bz4, x[4*N-1:3*N]);
            end
        end
    end

    function automatic logic [N*W-1:0] set_ch(input logic [N*W-1:0] v, input int ch, input int d);
        logic [N*W-1:0] t;
        t = v;
        t[ch*W +: W] = W'(d);
        return t;
    endfunction

    function automatic int pick_delay();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return 15;
            default: return int'($urandom_range(2, 24));
        endcase
    endfunction

    initial begin
        logic [N-1:0] e;
        drive(1'b1, 4'b0000, 3);

        // Zero delays: outputs follow with one cycle latency, busy never rises.
        drive(1'b0, 4'b0000, 5);
        drive(1'b0, 4'b0101, 10);
        drive(1'b0, 4'b0000, 5);

        // ch0 rise=5 fall=3.
        rd_next = set_ch('0, 0, 5);
        fd_next = set_ch('0, 0, 3);
        drive(1'b0, 4'b0001, 20);
        drive(1'b0, 4'b0000, 8);

        // Short pulse on ch1 suppressed, then a full-length one.
        rd_next = set_ch('0, 1, 8);
        fd_next = '0;
        drive(1'b0, 4'b0010, 4);
        drive(1'b0, 4'b0000, 5);
        drive(1'b0, 4'b0010, 15);
        drive(1'b0, 4'b0000, 4);

        // Re-arm ch2 during its fall wait.
        rd_next = '0;
        fd_next = set_ch('0, 2, 10);
        drive(1'b0, 4'b0100, 5);
        drive(1'b0, 4'b0000, 3);
        drive(1'b0, 4'b0100, 6);
        drive(1'b0, 4'b0000, 14);

        // Mid-count rise_delay change on ch3 is ignored.
        fd_next = '0;
        rd_next = set_ch('0, 3, 6);
        drive(1'b0, 4'b1000, 2);
        rd_next = set_ch('0, 3, 2);
        drive(1'b0, 4'b1000, 10);
        drive(1'b0, 4'b0000, 3);

        // All channels counting, then a one-cycle reset.
        rd_next = {16'd20, 16'd18, 16'd13, 16'd9};
        drive(1'b0, 4'b1111, 5);
        drive(1'b1, 4'b1111, 1);
        drive(1'b0, 4'b1111, 30);
        drive(1'b0, 4'b0000, 3);

        // Boundaries: 15 (max for W=4), 1, and mixed delays across channels.
        rd_next = {16'd15, 16'd1, 16'd7, 16'd3};
        fd_next = {16'd2, 16'd15, 16'd1, 16'd0};
        drive(1'b0, 4'b1111, 22);
        drive(1'b0, 4'b0000, 20);

        // Randomized traffic.
        e = '0;
        for (int it = 0; it < 800; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                int ch;
                ch = int'($urandom_range(0, N - 1));
                if ($urandom_range(0, 1) == 0) rd_next = set_ch(rd_next, ch, pick_delay());
                else                           fd_next = set_ch(fd_next, ch, pick_delay());
            end
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, 5) == 0) e[ch] = ~e[ch];
            end
            drive(($urandom_range(0, 199) == 0), e, 1);
        end
        drive(1'b0, 4'b0000, 30);

        @(posedge clk);
        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
